// File: rtl/booth_control_unit.sv
// Sequencer for a radix-2 Booth signed multiplier datapath.
// Walks load M, load Q, N test/add-or-subtract/shift iterations,
// drives A then Q onto the output bus, and pulses done.
// Outputs depend only on the registered state (Moore machine).
module booth_control_unit #(
    parameter int N     = 8,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    input  logic q0,
    input  logic q_m1,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c5,
    output logic c6,
    output logic busy,
    output logic done
);

    // Counter value reached during the final shift of an operation
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_M = 4'd1,
        LOAD_Q = 4'd2,
        TEST   = 4'd3,
        ADD    = 4'd4,
        SUB    = 4'd5,
        SHIFT  = 4'd6,
        OUT_A  = 4'd7,
        OUT_Q  = 4'd8,
        DONE   = 4'd9
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] iter_cnt;

    // State register; reset aborts any operation straight back to IDLE
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter: cleared on LOAD_M, advanced on every non-final shift
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            iter_cnt <= '0;
        end else if (state == LOAD_M) begin
            iter_cnt <= '0;
        end else if ((state == SHIFT) && (iter_cnt != LAST_ITER)) begin
            iter_cnt <= iter_cnt + CNT_W'(1);
        end
    end

    // Next-state decode and Moore strobe outputs
    always_comb begin
        state_nxt = state;
        c0        = 1'b0;
        c1        = 1'b0;
        c2        = 1'b0;
        c3        = 1'b0;
        c4        = 1'b0;
        c5        = 1'b0;
        c6        = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LOAD_M;
                end
            end
            LOAD_M: begin
                c0        = 1'b1;
                state_nxt = LOAD_Q;
            end
            LOAD_Q: begin
                c1        = 1'b1;
                state_nxt = TEST;
            end
            TEST: begin
                case ({q0, q_m1})
                    2'b10:   state_nxt = SUB;
                    2'b01:   state_nxt = ADD;
                    default: state_nxt = SHIFT;
                endcase
            end
            ADD: begin
                c2        = 1'b1;
                state_nxt = SHIFT;
            end
            SUB: begin
                c2        = 1'b1;
                c3        = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                c4 = 1'b1;
                if (iter_cnt == LAST_ITER) begin
                    state_nxt = OUT_A;
                end else begin
                    state_nxt = TEST;
                end
            end
            OUT_A: begin
                c5        = 1'b1;
                state_nxt = OUT_Q;
            end
            OUT_Q: begin
                c6        = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_control_unit.sv
// Directed testbench for booth_control_unit. A small behavioural Booth
// datapath (A with a guard bit, Q, Q[-1], M) follows the strobes so the
// product can be checked against hand-computed values.
module tb_booth_control_unit;

    logic clk;
    logic rst_b;
    logic start;
    logic q0;
    logic q_m1;
    logic c0, c1, c2, c3, c4, c5, c6;
    logic busy;
    logic done;

    int checkCount;
    int errorCount;

    logic [7:0] mVal;
    logic [7:0] qVal;
    logic [8:0] aReg;
    logic [8:0] mReg;
    logic [7:0] qReg;
    logic       qm1Reg;

    booth_control_unit #(.N(8), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .q0    (q0),
        .q_m1  (q_m1),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c5    (c5),
        .c6    (c6),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural datapath reacting to the strobes
    always @(posedge clk) begin
        if (c0) begin
            aReg   <= '0;
            qm1Reg <= 1'b0;
            mReg   <= {mVal[7], mVal};
        end
        if (c1) begin
            qReg <= qVal;
        end
        if (c2) begin
            aReg <= c3 ? (aReg - mReg) : (aReg + mReg);
        end
        if (c4) begin
            {aReg, qReg, qm1Reg} <= {aReg[8], aReg, qReg};
        end
    end

    assign q0   = qReg[0];
    assign q_m1 = qm1Reg;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one multiplication and checks the strobe sequence and the product
    task automatic applyStimulus(input string tag, input logic [7:0] mv,
                                 input logic [7:0] qv, input bit holdStart,
                                 input bit toggleStart, input int expCycles,
                                 input int expC2, input logic [7:0] expPat,
                                 input logic [15:0] expProd);
        int guard;
        int cycles;
        int c2Cnt;
        int c4Cnt;
        int c5At;
        int c6At;
        logic [7:0] pat;
        bit strobeOk;
        mVal  = mv;
        qVal  = qv;
        start = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!c0 && guard < 8);
        checkOutput({tag, "_loadm"}, 32'(c0), 32'd1);
        if (!holdStart) start = 1'b0;
        cycles   = 0;
        c2Cnt    = 0;
        c4Cnt    = 0;
        c5At     = 0;
        c6At     = 0;
        pat      = '0;
        strobeOk = 1'b1;
        while (1) begin
            cycles++;
            if (c2) begin
                c2Cnt++;
                pat = {pat[6:0], c3};
            end
            if (c3 && !c2) strobeOk = 1'b0;
            if ($countones({c0, c1, c2, c4, c5, c6}) > 1) strobeOk = 1'b0;
            if (!busy) strobeOk = 1'b0;
            if (c4) c4Cnt++;
            if (c5) c5At = cycles;
            if (c6) c6At = cycles;
            if (done || cycles >= 60) break;
            @(negedge clk);
            if (toggleStart) start = ~start;
        end
        if (toggleStart) start = 1'b0;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_cycles"}, 32'(cycles), 32'(expCycles));
        checkOutput({tag, "_c2count"}, 32'(c2Cnt), 32'(expC2));
        checkOutput({tag, "_c3pattern"}, 32'(pat), 32'(expPat));
        checkOutput({tag, "_c4count"}, 32'(c4Cnt), 32'd8);
        checkOutput({tag, "_c5pos"}, 32'(c5At), 32'(expCycles - 2));
        checkOutput({tag, "_c6pos"}, 32'(c6At), 32'(expCycles - 1));
        checkOutput({tag, "_strobes"}, 32'(strobeOk), 32'd1);
        checkOutput({tag, "_product"}, 32'({aReg[7:0], qReg}), 32'(expProd));
        if (holdStart) begin
            @(negedge clk);
            checkOutput({tag, "_idlegap"}, 32'({busy, c0}), 32'd0);
            @(negedge clk);
            checkOutput({tag, "_restart"}, 32'(c0), 32'd1);
            start = 1'b0;
            guard = 0;
            while (!done && guard < 60) begin
                @(negedge clk);
                guard++;
            end
            checkOutput({tag, "_restartdone"}, 32'(done), 32'd1);
        end
        @(negedge clk);
    endtask

    // Main directed sequence
    initial begin
        int guard;
        checkCount = 0;
        errorCount = 0;
        rst_b = 1'b0;
        start = 1'b0;
        mVal  = '0;
        qVal  = '0;
        #2;
        checkOutput("reset_outputs", 32'({c0, c1, c2, c3, c4, c5, c6, busy, done}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", 32'({busy, c0}), 32'd0);

        // Abort a running operation in the middle of a shift
        mVal  = 8'h03;
        qVal  = 8'h55;
        start = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (c0) start = 1'b0;
        end while (!c4 && guard < 30);
        checkOutput("abort_in_shift", 32'(c4), 32'd1);
        start = 1'b0;
        rst_b = 1'b0;
        #1;
        checkOutput("abort_outputs", 32'({c0, c1, c2, c3, c4, c5, c6, busy, done}), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        checkOutput("release_outputs", 32'({c0, c1, c2, c3, c4, c5, c6, busy, done}), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("stay_idle", 32'({busy, c0}), 32'd0);

        // Zero multiplier: shifts only
        applyStimulus("q00", 8'h07, 8'h00, 1'b0, 1'b0, 21, 0, 8'h00, 16'h0000);
        // Alternating SUB/ADD, start toggled while busy
        applyStimulus("q55", 8'h03, 8'h55, 1'b0, 1'b1, 29, 8, 8'hAA, 16'h00FF);
        // -1 times 5: a single SUB on the first iteration
        applyStimulus("qff", 8'h05, 8'hFF, 1'b0, 1'b0, 22, 1, 8'h01, 16'hFFFB);
        // -128 times -128: SUB on the final iteration only
        applyStimulus("q80", 8'h80, 8'h80, 1'b0, 1'b0, 22, 1, 8'h01, 16'h4000);
        // start held high across completion
        applyStimulus("hold", 8'h02, 8'h00, 1'b1, 1'b0, 21, 0, 8'h00, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
